// File: rtl/linebuffer_pkg.sv
// Shared types and sizing helpers for the line-buffer window generator.
package linebuffer_pkg;

  // Top-of-frame border policy for lines that have not arrived yet.
  typedef enum logic {
    BORDER_ZERO = 1'b0,
    BORDER_REPL = 1'b1
  } border_e;

  // Column counter / out_col width: indexes 0..max_width-1.
  function automatic int unsigned col_w(input int unsigned max_width);
    return (max_width < 2) ? 1 : $clog2(max_width);
  endfunction

  // cfg_width / latched width: must hold the value max_width itself.
  function automatic int unsigned cfg_w(input int unsigned max_width);
    return $clog2(max_width + 1);
  endfunction

  // Row counter width: holds 0..lines-1 (saturating value).
  function automatic int unsigned row_w(input int unsigned lines);
    return (lines < 2) ? 1 : $clog2(lines);
  endfunction

  // Legal parameter set: odd window height in 3..9, at least two columns.
  function automatic bit params_legal(input int unsigned lines,
                                      input int unsigned max_width,
                                      input int unsigned border);
    return (lines >= 3) && (lines <= 9) && (lines % 2 == 1) &&
           (max_width >= 2) && (border <= 1);
  endfunction

endpackage

// File: rtl/linebuffer_win_ram.sv
// Single-port, read-first synchronous RAM with a registered read port.
// The cascade port exposes the addressed word so the next RAM in the line
// shift chain can store it in the same cycle this RAM overwrites it.
module lb_ram #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic [WIDTH-1:0] o_cascade
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Storage array write on every enabled access.
  // NOTE: the array itself has no reset; stale lines are hidden by the
  // border mask, and a reset loop would prevent block-RAM inference.
  always_ff @(posedge clk) begin
    if (i_en) r_mem[i_addr] <= i_wdata;
  end

  // Registered read of the old word (read-first).
  // NOTE: non-blocking assignments let the read sample the word before the
  // write above replaces it, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst)       r_rdata <= '0;
    else if (i_en) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata   = r_rdata;
  assign o_cascade = r_mem[i_addr];

endmodule

// File: rtl/linebuffer_win.sv
// Vertical window generator: one registered column of DATA_LINES pixels per
// accepted input pixel, with top-border fill and per-column position flags.
module linebuffer_win
  import linebuffer_pkg::*;
#(
  parameter int DATA_LINES = 3,
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 1,
  parameter int MAX_WIDTH  = 1024,
  parameter int BORDER     = 0
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [cfg_w(MAX_WIDTH)-1:0]                cfg_width,
  input  logic                                       in_valid,
  input  logic                                       in_sof,
  input  logic [CHANNELS*DATA_WIDTH-1:0]             in_data,
  output logic                                       out_valid,
  output logic [DATA_LINES*CHANNELS*DATA_WIDTH-1:0]  out_data,
  output logic                                       out_sof,
  output logic                                       out_sol,
  output logic                                       out_eol,
  output logic [col_w(MAX_WIDTH)-1:0]                out_col
);

  localparam int COL_W = col_w(MAX_WIDTH);
  localparam int CFG_W = cfg_w(MAX_WIDTH);
  localparam int ROW_W = row_w(DATA_LINES);
  localparam int PIX_W = CHANNELS * DATA_WIDTH;
  localparam int NRAM  = DATA_LINES - 1;

  localparam logic [CFG_W-1:0] MAXW     = CFG_W'(MAX_WIDTH);
  localparam logic [ROW_W-1:0] ROW_SAT  = ROW_W'(DATA_LINES - 1);
  localparam border_e          BORDER_MODE = (BORDER != 0) ? BORDER_REPL : BORDER_ZERO;

  if (!params_legal(DATA_LINES, MAX_WIDTH, BORDER)) begin : g_bad_params
    $error("linebuffer_win: DATA_LINES must be odd in 3..9, MAX_WIDTH >= 2, BORDER in 0..1");
  end

  // Frame position state.
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic [CFG_W-1:0] r_width;

  // Output-stage registers (RAM read registers live inside lb_ram).
  logic             r_out_valid;
  logic             r_out_sof;
  logic             r_out_sol;
  logic             r_out_eol;
  logic [COL_W-1:0] r_out_col;
  logic [ROW_W-1:0] r_out_row;
  logic [PIX_W-1:0] r_cur;

  // Position of the pixel being accepted; in_sof restarts the frame.
  logic             w_accept;
  logic [CFG_W-1:0] w_cfg_width;
  logic [CFG_W-1:0] w_width;
  logic [COL_W-1:0] w_col;
  logic [ROW_W-1:0] w_row;
  logic             w_last;
  logic [COL_W-1:0] w_col_next;
  logic [ROW_W-1:0] w_row_next;

  assign w_accept    = in_valid & ~rst;
  assign w_cfg_width = ((cfg_width == '0) || (cfg_width > MAXW)) ? MAXW : cfg_width;
  assign w_width     = in_sof ? w_cfg_width : r_width;
  assign w_col       = in_sof ? '0 : r_col;
  assign w_row       = in_sof ? '0 : r_row;
  assign w_last      = (CFG_W'(w_col) == (w_width - CFG_W'(1)));
  assign w_col_next  = w_last ? '0 : (w_col + COL_W'(1));
  assign w_row_next  = (w_last && (w_row != ROW_SAT)) ? (w_row + ROW_W'(1)) : w_row;

  // Advance column/row counters and latch the line length per pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col   <= '0;
      r_row   <= '0;
      r_width <= MAXW;
    end else if (in_valid) begin
      r_col   <= w_col_next;
      r_row   <= w_row_next;
      r_width <= w_width;
    end
  end

  // Register strobe and flags every cycle; column data only on accepted pixels.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_sof   <= 1'b0;
      r_out_sol   <= 1'b0;
      r_out_eol   <= 1'b0;
      r_out_col   <= '0;
      r_out_row   <= '0;
      r_cur       <= '0;
    end else begin
      r_out_valid <= in_valid;
      r_out_sof   <= in_valid & in_sof;
      r_out_sol   <= in_valid & (w_col == '0);
      r_out_eol   <= in_valid & w_last;
      if (in_valid) begin
        r_out_col <= w_col;
        r_out_row <= w_row;
        r_cur     <= in_data;
      end
    end
  end

  // Line shift chain: RAM0 takes the new pixel, RAM k takes RAM k-1's old word.
  logic [PIX_W-1:0] w_ram_q     [NRAM];
  logic [PIX_W-1:0] w_ram_casc  [NRAM];
  logic [PIX_W-1:0] w_ram_wdata [NRAM];

  for (genvar k = 0; k < NRAM; k++) begin : g_line
    if (k == 0) begin : g_head
      assign w_ram_wdata[k] = in_data;
    end else begin : g_link
      assign w_ram_wdata[k] = w_ram_casc[k-1];
    end

    lb_ram #(
      .DEPTH (MAX_WIDTH),
      .WIDTH (PIX_W),
      .AW    (COL_W)
    ) u_ram (
      .clk       (clk),
      .rst       (rst),
      .i_en      (w_accept),
      .i_addr    (w_col),
      .i_wdata   (w_ram_wdata[k]),
      .o_rdata   (w_ram_q[k]),
      .o_cascade (w_ram_casc[k])
    );
  end

  // Border mask: taps older than the lines received so far are zeroed or
  // replaced by the frame's first line.
  logic [PIX_W-1:0]            w_raw [DATA_LINES];
  logic [ROW_W-1:0]            w_repl_idx;
  logic [PIX_W-1:0]            w_repl;
  logic [DATA_LINES*PIX_W-1:0] w_out_data;

  // NOTE: every combinational output gets a default before any branch so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    w_raw[DATA_LINES-1] = r_cur;
    for (int k = 0; k < NRAM; k++) begin
      w_raw[DATA_LINES-2-k] = w_ram_q[k];
    end
    w_repl_idx = ROW_SAT - r_out_row;
    w_repl     = w_raw[w_repl_idx];
    w_out_data = '0;
    for (int t = 0; t < DATA_LINES; t++) begin
      if ((DATA_LINES - 1 - t) <= int'(r_out_row)) begin
        w_out_data[t*PIX_W +: PIX_W] = w_raw[t];
      end else if (BORDER_MODE == BORDER_REPL) begin
        w_out_data[t*PIX_W +: PIX_W] = w_repl;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = w_out_data;
  assign out_sof   = r_out_sof;
  assign out_sol   = r_out_sol;
  assign out_eol   = r_out_eol;
  assign out_col   = r_out_col;

endmodule
